// File: rtl/mod_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_updown_counter
// Description : Synchronous modulo-MODULUS up/down counter with clock-enable
//               prescaler, synchronous clear/load, wrap or saturate mode and
//               a registered terminal-count pulse for cascading.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             at_max
);

    // Prescaler is at least one bit wide so PRESCALE=1 needs no special case:
    // its last value is 0, so step simply follows en.
    localparam int                 c_PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PSC_W-1:0] c_PSC_LAST = c_PSC_W'(PRESCALE - 1);
    localparam logic [c_PSC_W-1:0] c_PSC_ONE  = c_PSC_W'(1);
    localparam logic [WIDTH-1:0]   c_MAX      = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0]   c_ONE      = WIDTH'(1);

    // Reject parameter sets that would make the count range meaningless.
    generate
        if ((MODULUS < 2) || (longint'(MODULUS) > (longint'(1) << WIDTH))) begin : g_bad_modulus
            $error("mod_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("mod_updown_counter: PRESCALE must be >= 1");
        end
    endgenerate

    logic [c_PSC_W-1:0] r_psc;
    logic [WIDTH-1:0]   r_q;
    logic               r_tc;
    logic               r_at_max;
    logic               w_step;
    logic [WIDTH-1:0]   w_q_next;
    logic               w_tc_next;

    assign w_step = en && (r_psc == c_PSC_LAST);

    // Prescaler: advances on every enabled clock, restarts on clear/load/reset.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_psc <= '0;
        end else if (clr || load) begin
            r_psc <= '0;
        end else if (en) begin
            r_psc <= (r_psc == c_PSC_LAST) ? '0 : (r_psc + c_PSC_ONE);
        end
    end

    // Next count and terminal-count: clr > load > step > hold, modulo MODULUS.
    always_comb begin
        w_q_next  = r_q;
        w_tc_next = 1'b0;
        if (clr) begin
            w_q_next = '0;
        end else if (load) begin
            // Out-of-range load values are clamped so q never leaves 0..MODULUS-1.
            w_q_next = (load_val > c_MAX) ? c_MAX : load_val;
        end else if (w_step) begin
            if (up_dn) begin
                if (r_q == c_MAX) begin
                    w_tc_next = 1'b1;
                    if (!sat_mode) begin
                        w_q_next = '0;
                    end
                end else begin
                    w_q_next = r_q + c_ONE;
                end
            end else begin
                if (r_q == '0) begin
                    w_tc_next = 1'b1;
                    if (!sat_mode) begin
                        w_q_next = c_MAX;
                    end
                end else begin
                    w_q_next = r_q - c_ONE;
                end
            end
        end
    end

    // Output registers; at_max is derived from the next count so it tracks q exactly.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_q      <= '0;
            r_tc     <= 1'b0;
            r_at_max <= 1'b0;
        end else begin
            r_q      <= w_q_next;
            r_tc     <= w_tc_next;
            r_at_max <= (w_q_next == c_MAX);
        end
    end

    assign q      = r_q;
    assign tc     = r_tc;
    assign at_max = r_at_max;

endmodule
`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_updown_counter
// Description : Self-checking bench for mod_updown_counter: PRESCALE=1 and
//               PRESCALE=3 instances plus a two-stage decade cascade.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: PRESCALE=1
    logic       a_rst = 1'b1, a_clr = 1'b0, a_load = 1'b0, a_en = 1'b0, a_up = 1'b1, a_sat = 1'b0;
    logic [3:0] a_lv = 4'd0;
    logic [3:0] a_q;
    logic       a_tc, a_max;

    // Instance B: PRESCALE=3
    logic       b_rst = 1'b1, b_clr = 1'b0, b_load = 1'b0, b_en = 1'b0, b_up = 1'b1, b_sat = 1'b0;
    logic [3:0] b_lv = 4'd0;
    logic [3:0] b_q;
    logic       b_tc, b_max;

    // Cascade: units -> tens
    logic       c_rst = 1'b1, c_en = 1'b0, c_zero = 1'b0, c_one = 1'b1;
    logic [3:0] c_lv = 4'd0;
    logic [3:0] u_q, t_q;
    logic       u_tc, u_max, t_tc, t_max;

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut_a (
        .clk(clk), .reset_p(a_rst), .clr(a_clr), .load(a_load), .load_val(a_lv),
        .en(a_en), .up_dn(a_up), .sat_mode(a_sat), .q(a_q), .tc(a_tc), .at_max(a_max));

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) dut_b (
        .clk(clk), .reset_p(b_rst), .clr(b_clr), .load(b_load), .load_val(b_lv),
        .en(b_en), .up_dn(b_up), .sat_mode(b_sat), .q(b_q), .tc(b_tc), .at_max(b_max));

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut_units (
        .clk(clk), .reset_p(c_rst), .clr(c_zero), .load(c_zero), .load_val(c_lv),
        .en(c_en), .up_dn(c_one), .sat_mode(c_zero), .q(u_q), .tc(u_tc), .at_max(u_max));

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut_tens (
        .clk(clk), .reset_p(c_rst), .clr(c_zero), .load(c_zero), .load_val(c_lv),
        .en(u_tc), .up_dn(c_one), .sat_mode(c_zero), .q(t_q), .tc(t_tc), .at_max(t_max));

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic clr_i, input logic load_i, input logic [3:0] lv_i,
                           input logic en_i, input logic up_i, input logic sat_i);
        a_clr = clr_i; a_load = load_i; a_lv = lv_i; a_en = en_i; a_up = up_i; a_sat = sat_i;
    endtask

    // Reference model of one counter edge, written from the counting rules:
    // a step moves q by +/-1 within 0..M-1; leaving the range is a boundary
    // (tc) that either wraps modulo M or leaves q where it was.
    function automatic void model_edge(input int p, input bit clr_i, input bit load_i, input int lv,
                                       input bit en_i, input bit up_i, input bit sat_i,
                                       inout int mq, inout int mpsc, output bit mtc);
        int  raw;
        bit  step;
        step = en_i && (mpsc == p - 1);
        mtc  = 1'b0;
        if (clr_i) begin
            mq = 0; mpsc = 0;
        end else if (load_i) begin
            mq = (lv >= 10) ? 9 : lv; mpsc = 0;
        end else begin
            if (en_i) mpsc = (mpsc + 1) % p;
            if (step) begin
                raw = up_i ? mq + 1 : mq - 1;
                if (raw < 0 || raw >= 10) begin
                    mtc = 1'b1;
                    if (!sat_i) mq = (raw + 10) % 10;
                end else begin
                    mq = raw;
                end
            end
        end
    endfunction

    task automatic test_reset();
        #2;
        checks++;
        if ({a_q, a_tc, a_max} !== 6'b0 || {b_q, b_tc, b_max} !== 6'b0) begin
            errors++;
            $display("FAIL reset_async a=%h/%b/%b b=%h/%b/%b expected 0/0/0", a_q, a_tc, a_max, b_q, b_tc, b_max);
        end
        a_en = 1'b1; b_en = 1'b1;
        tick(); tick();
        checks++;
        if ({a_q, a_tc, a_max} !== 6'b0 || {b_q, b_tc, b_max} !== 6'b0) begin
            errors++;
            $display("FAIL reset_hold a=%h/%b/%b b=%h/%b/%b expected 0/0/0", a_q, a_tc, a_max, b_q, b_tc, b_max);
        end
        a_en = 1'b0; b_en = 1'b0;
        a_rst = 1'b0; b_rst = 1'b0;
    endtask

    task automatic test_count_up();
        a_drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            int eq;
            tick();
            eq = i % 10;
            checks++;
            if (a_q !== 4'(eq) || a_tc !== (i == 10) || a_max !== (eq == 9)) begin
                errors++;
                $display("FAIL count_up clk%0d got q=%0d tc=%b max=%b expected q=%0d tc=%b max=%b",
                         i, a_q, a_tc, a_max, eq, (i == 10), (eq == 9));
            end
        end
        a_en = 1'b0;
    endtask

    task automatic test_prescale();
        b_rst = 1'b1; #1; b_rst = 1'b0;
        b_en = 1'b1; b_up = 1'b1; b_sat = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            checks++;
            if (b_q !== 4'(i / 3) || b_tc !== 1'b0) begin
                errors++;
                $display("FAIL prescale clk%0d got q=%0d tc=%b expected q=%0d tc=0", i, b_q, b_tc, i / 3);
            end
        end
        // One enabled clock, pause five, then two more enabled clocks to step.
        tick();
        b_en = 1'b0;
        repeat (5) tick();
        b_en = 1'b1;
        tick();
        checks++;
        if (b_q !== 4'd3) begin
            errors++;
            $display("FAIL prescale_frozen_early got q=%0d expected 3", b_q);
        end
        tick();
        checks++;
        if (b_q !== 4'd4) begin
            errors++;
            $display("FAIL prescale_frozen_resume got q=%0d expected 4", b_q);
        end
        b_en = 1'b0;
    endtask

    task automatic test_boundaries();
        a_drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0); tick();
        a_drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0); tick();
        checks++;
        if ({a_q, a_tc, a_max} !== {4'd9, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL down_wrap got q=%0d tc=%b max=%b expected 9/1/1", a_q, a_tc, a_max);
        end
        a_drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1); tick();
        a_drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({a_q, a_tc, a_max} !== {4'd0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL down_sat step%0d got q=%0d tc=%b max=%b expected 0/1/0", i, a_q, a_tc, a_max);
            end
        end
        a_drive(1'b0, 1'b1, 4'd9, 1'b0, 1'b1, 1'b1); tick();
        a_drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({a_q, a_tc, a_max} !== {4'd9, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL up_sat step%0d got q=%0d tc=%b max=%b expected 9/1/1", i, a_q, a_tc, a_max);
            end
        end
        a_en = 1'b0; tick();
        checks++;
        if (a_tc !== 1'b0 || a_q !== 4'd9) begin
            errors++;
            $display("FAIL tc_single_pulse got q=%0d tc=%b expected 9/0", a_q, a_tc);
        end
    endtask

    task automatic test_load();
        logic [3:0] lv_tab [4] = '{4'd7, 4'd13, 4'd6, 4'd4};
        logic       clr_tab[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic       en_tab [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0] exp_tab[4] = '{4'd7, 4'd9, 4'd0, 4'd4};
        for (int i = 0; i < 4; i++) begin
            a_drive(clr_tab[i], 1'b1, lv_tab[i], en_tab[i], 1'b1, 1'b0);
            tick();
            checks++;
            if ({a_q, a_tc, a_max} !== {exp_tab[i], 1'b0, (exp_tab[i] == 4'd9)}) begin
                errors++;
                $display("FAIL load%0d got q=%0d tc=%b max=%b expected q=%0d tc=0", i, a_q, a_tc, a_max, exp_tab[i]);
            end
        end
        a_drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        b_lv = 4'd5; b_load = 1'b1; tick();
        b_load = 1'b0; b_en = 1'b1; tick();
        checks++;
        if (b_q !== 4'd5) begin
            errors++;
            $display("FAIL areset_setup got q=%0d expected 5", b_q);
        end
        #2; b_rst = 1'b1; #1;
        checks++;
        if ({b_q, b_tc, b_max} !== 6'b0) begin
            errors++;
            $display("FAIL areset_immediate got q=%0d tc=%b max=%b expected 0/0/0", b_q, b_tc, b_max);
        end
        tick();
        b_rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (b_q !== 4'(i / 3)) begin
                errors++;
                $display("FAIL areset_restart clk%0d got q=%0d expected %0d", i, b_q, i / 3);
            end
        end
        b_en = 1'b0;
    endtask

    task automatic test_random();
        int  qa, pa, qb, pb;
        bit  ta, tb;
        a_rst = 1'b1; b_rst = 1'b1; #1; a_rst = 1'b0; b_rst = 1'b0;
        qa = 0; pa = 0; qb = 0; pb = 0;
        for (int i = 0; i < 400; i++) begin
            a_drive(($urandom_range(0, 29) == 0), ($urandom_range(0, 14) == 0), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 3) == 0));
            b_clr = ($urandom_range(0, 29) == 0); b_load = ($urandom_range(0, 14) == 0);
            b_lv = 4'($urandom_range(0, 15)); b_en = ($urandom_range(0, 3) != 0);
            b_up = 1'($urandom); b_sat = ($urandom_range(0, 3) == 0);
            model_edge(1, a_clr, a_load, int'(a_lv), a_en, a_up, a_sat, qa, pa, ta);
            model_edge(3, b_clr, b_load, int'(b_lv), b_en, b_up, b_sat, qb, pb, tb);
            tick();
            checks++;
            if ({a_q, a_tc, a_max} !== {4'(qa), ta, (qa == 9)} || {b_q, b_tc, b_max} !== {4'(qb), tb, (qb == 9)}) begin
                errors++;
                $display("FAIL random cyc%0d a=%0d/%b/%b exp %0d/%b b=%0d/%b/%b exp %0d/%b",
                         i, a_q, a_tc, a_max, qa, ta, b_q, b_tc, b_max, qb, tb);
            end
        end
        a_drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        b_clr = 1'b0; b_load = 1'b0; b_en = 1'b0;
    endtask

    task automatic test_cascade();
        int eu, et;
        c_rst = 1'b0; c_en = 1'b1;
        for (int k = 1; k <= 105; k++) begin
            tick();
            eu = k % 10;
            et = ((k - 1) / 10) % 10;
            checks++;
            if (u_q !== 4'(eu) || t_q !== 4'(et) || u_tc !== (eu == 0) || t_tc !== (k == 101)) begin
                errors++;
                $display("FAIL cascade clk%0d got tens=%0d units=%0d tc=%b/%b expected %0d%0d tc=%b/%b",
                         k, t_q, u_q, t_tc, u_tc, et, eu, (k == 101), (eu == 0));
            end
        end
        c_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_count_up();
        test_prescale();
        test_boundaries();
        test_load();
        test_async_reset();
        test_random();
        test_cascade();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mod_updown_counter.md
# mod_updown_counter

Parametrised synchronous modulo-N up/down counter with a built-in clock-enable prescaler, synchronous load/clear and a wrap or saturate mode. It is the general-purpose successor to the fixed 2-bit ripple up-counter. All bits change on one rising clock edge, so there is no ripple skew, and a terminal-count pulse is provided for cascading. It is clocked by the board clock, e.g. the 555 astable output after synchronisation, and drives display/decoder logic.

## Interface
- WIDTH, 4: counter width in bits; must satisfy 2 ≤ MODULUS ≤ 2**WIDTH (elaboration error otherwise)
- MODULUS, 10: count range 0 .. MODULUS-1
- PRESCALE, 1: counter steps once every PRESCALE enabled clocks; must be ≥ 1
- clk  in  1  rising-edge clock
- reset_p  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear
- load  in  1  synchronous parallel load
- load_val  in  WIDTH  value for load
- en  in  1  count enable (gates prescaler)
- up_dn  in  1  1 = count up, 0 = count down
- sat_mode  in  1  1 = saturate at boundary, 0 = wrap
- q  out  WIDTH  registered count
- tc  out  1  registered terminal-count pulse
- at_max  out  1  registered flag, q == MODULUS-1

## Operation
- Internal prescaler psc, range 0 .. PRESCALE-1, width clog2(PRESCALE) (minimum 1 bit).
- step = en && (psc == PRESCALE-1). When en=1, psc increments and wraps to 0. When en=0, psc holds.
- PRESCALE=1: step = en.
- Per-edge priority: clr > load > step > hold.
- clr: q←0, psc←0, tc←0.
- load: q←load_val if load_val < MODULUS, else q←MODULUS-1 (clamped); psc←0; tc←0. Load acts regardless of en.
- Step, up, q < MODULUS-1: q←q+1.
- Step, up, q == MODULUS-1: wrap mode q←0; saturate mode q holds. tc←1 in both modes.
- Step, down, q > 0: q←q-1.
- Step, down, q == 0: wrap mode q←MODULUS-1; saturate mode q holds. tc←1 in both modes.
- Any other edge: tc←0, so tc is a single-cycle pulse per boundary step.
- at_max is registered alongside q, so at_max == (q == MODULUS-1) always holds.
- up_dn and sat_mode are sampled only at step edges. Changing them between steps has no effect until the next step.
- Arithmetic is modulo MODULUS, never modulo 2**WIDTH. Values ≥ MODULUS are unreachable.

## Timing
- reset_p=1: immediately and asynchronously q=0, psc=0, tc=0, at_max=0 (at_max=1 if MODULUS==1, which is excluded). Outputs hold while reset_p is high.
- First step after reset release needs PRESCALE enabled clocks.
- Reset mid-count abandons the partial prescale; psc restarts from 0.
- Latency: q, tc and at_max update on the same rising edge as the qualifying step/load/clr. There is no combinational path from inputs to outputs.
- clr and load on the same edge: clr wins. load and step on the same edge: load wins and the step is dropped.
- Cascading: the next stage's en is driven from this stage's tc. That stage then steps one cycle after the boundary edge, which is a documented one-cycle skew.
- Saturate mode at a boundary: tc pulses on every step while q is held at the limit.

## Test plan
- MODULUS=10, PRESCALE=1, up, wrap, en=1 for 12 clocks from reset → q = 1..9, 0, 1, 2; tc=1 only in the cycle q becomes 0; at_max=1 only while q=9.
- PRESCALE=3, en=1 for 9 clocks → q advances on clocks 3, 6 and 9 only (0→1→2→3). Dropping en for 5 clocks mid-prescale then resuming → step resumes from the frozen psc.
- Down, wrap, from q=0, one step → q=9, tc=1. Down, saturate, from q=0 → q stays 0, tc=1 for each step.
- load=1, load_val=7 → q=7 next edge. load_val=13 → q=9 (clamped). load with clr=1 → q=0. load with a qualifying step → q=load value, no step.
- reset_p pulsed asynchronously between clock edges at q=5 → q=0 and tc=0 before the next edge. After release, the first step occurs PRESCALE clocks later.
- Two instances cascaded (units tc → tens en), both MODULUS=10, 100 steps → tens:units wraps 99→00, and the tens stage shows the one-cycle lag.
